// File: rtl/ram_loader_pkg.sv
// Shared definitions for ram_loader: FSM state encodings, RAM operation codes,
// byte-lane select masks and lane helper functions.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic RAM_OP_WRITE = 1'b1;
  localparam logic RAM_OP_READ  = 1'b0;

  localparam logic [3:0] SEL_1B   = 4'b1000;
  localparam logic [3:0] SEL_2B   = 4'b1100;
  localparam logic [3:0] SEL_3B   = 4'b1110;
  localparam logic [3:0] SEL_FULL = 4'b1111;

  // Bytes fill from the most significant lane down, so a partial word keeps the high lanes.
  function automatic logic [3:0] sel_for_lanes(input logic [2:0] lanes);
    case (lanes)
      3'd1:    sel_for_lanes = SEL_1B;
      3'd2:    sel_for_lanes = SEL_2B;
      3'd3:    sel_for_lanes = SEL_3B;
      default: sel_for_lanes = SEL_FULL;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/ram_loader_packer.sv
// Big-endian byte packer: places each accepted byte into the next free lane and
// reports the word, lane count and select mask as they stand after the current push.
module ram_loader_packer
  import ram_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic [2:0]  lanes_nxt,
  output logic [3:0]  sel_nxt
);

  logic [31:0] word_q, word_d;
  logic [1:0]  lanes_q, lanes_d;

  always_comb begin
    word_nxt  = word_q;
    lanes_nxt = {1'b0, lanes_q};
    if (push) begin
      case (lanes_q)
        2'd0:    word_nxt[31:24] = byte_in;
        2'd1:    word_nxt[23:16] = byte_in;
        2'd2:    word_nxt[15:8]  = byte_in;
        default: word_nxt[7:0]   = byte_in;
      endcase
      lanes_nxt = {1'b0, lanes_q} + 3'd1;
    end
    sel_nxt = sel_for_lanes(lanes_nxt);
  end

  // Clear wins over push: the word that completes on this push is consumed by the caller.
  always_comb begin
    word_d  = word_q;
    lanes_d = lanes_q;
    if (clear) begin
      word_d  = '0;
      lanes_d = '0;
    end else if (push) begin
      word_d  = word_nxt;
      lanes_d = lanes_nxt[1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      lanes_q <= '0;
    end else begin
      word_q  <= word_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// RAM loader: collects a host byte stream, packs it big-endian and writes 32-bit
// words to RAM. Define RAM_LOADER_VERIFY_EN to read back and check each written word.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  input  logic [COUNT_WIDTH-1:0] byte_count,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   ram_chip_enable,
  output logic                   ram_operation,
  output logic [31:0]            ram_addr,
  output logic [3:0]             ram_select_signal,
  output logic [31:0]            ram_write_data,
  input  logic [31:0]            ram_read_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]            cur_addr_q, cur_addr_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ce_q, ce_d;
  logic                   op_q, op_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             sel_q, sel_d;
  logic [31:0]            wdata_q, wdata_d;

  logic        accept, last_byte, pk_clear;
  logic [31:0] pk_word;
  logic [2:0]  pk_lanes;
  logic [3:0]  pk_sel;

`ifdef RAM_LOADER_VERIFY_EN
  logic        error_q, error_d;
  logic [31:0] vword_q, vword_d;
`endif

  assign accept    = in_valid && in_ready_q;
  assign last_byte = (remaining_q == COUNT_WIDTH'(1));

  ram_loader_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (pk_clear),
    .push      (accept),
    .byte_in   (in_data),
    .word_nxt  (pk_word),
    .lanes_nxt (pk_lanes),
    .sel_nxt   (pk_sel)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_addr_d  = cur_addr_q;
    in_ready_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ce_d        = 1'b0;
    op_d        = RAM_OP_READ;
    addr_d      = '0;
    sel_d       = '0;
    wdata_d     = '0;
    pk_clear    = 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
    error_d     = error_q;
    vword_d     = vword_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          pk_clear    = 1'b1;
          cur_addr_d  = {base_addr[31:2], 2'b00};
          remaining_d = byte_count;
          busy_d      = 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
          error_d     = 1'b0;
`endif
          if (byte_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_COLLECT;
            in_ready_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        in_ready_d = 1'b1;
        if (accept) begin
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          if (pk_lanes[2] || last_byte) begin
            pk_clear   = 1'b1;
            state_d    = ST_WRITE;
            in_ready_d = 1'b0;
            ce_d       = 1'b1;
            op_d       = RAM_OP_WRITE;
            addr_d     = cur_addr_q;
            sel_d      = pk_sel;
            wdata_d    = pk_word;
          end
        end
      end
      ST_WRITE: begin
        cur_addr_d = cur_addr_q + 32'd4;
`ifdef RAM_LOADER_VERIFY_EN
        state_d = ST_VERIFY;
        ce_d    = 1'b1;
        op_d    = RAM_OP_READ;
        addr_d  = addr_q;
        sel_d   = sel_q;
        vword_d = wdata_q;
`else
        if (remaining_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_COLLECT;
          in_ready_d = 1'b1;
        end
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (((ram_read_data ^ vword_q) & lane_mask(sel_q)) != '0) error_d = 1'b1;
        if (remaining_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_COLLECT;
          in_ready_d = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      cur_addr_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ce_q        <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
`ifdef RAM_LOADER_VERIFY_EN
      error_q     <= 1'b0;
      vword_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_addr_q  <= cur_addr_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ce_q        <= ce_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
`ifdef RAM_LOADER_VERIFY_EN
      error_q     <= error_d;
      vword_q     <= vword_d;
`endif
    end
  end

  assign in_ready          = in_ready_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign ram_chip_enable   = ce_q;
  assign ram_operation     = op_q;
  assign ram_addr          = addr_q;
  assign ram_select_signal = sel_q;
  assign ram_write_data    = wdata_q;

`ifdef RAM_LOADER_VERIFY_EN
  assign error = error_q;
  logic unused_bits;
  assign unused_bits = ^base_addr[1:0];
`else
  assign error = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{base_addr[1:0], ram_read_data};
`endif

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of byte_count and internal byte counter.
REQ-002 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; begins a load when idle.
REQ-005 SHALL have port base_addr  input  32  word-aligned first RAM address; bits [1:0] ignored.
REQ-006 SHALL have port byte_count  input  COUNT_WIDTH  number of bytes to load.
REQ-007 SHALL have port in_valid / in_data  input  1 / 8  byte stream from host.
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-009 SHALL have ports ram_chip_enable, ram_operation (1=write, 0=read)  output  1 each.
REQ-010 SHALL have ports ram_addr  output  32; ram_select_signal  output  4; ram_write_data  output  32; ram_read_data  input  32.
REQ-011 SHALL have ports busy  output  1; done  output  1 (one-cycle pulse); error  output  1 (sticky).

Function
REQ-012 SHALL act as RAM-bus initiator: RAM writes on rising clock edge when chip_enable=1 and operation=1; ram_read_data is valid combinationally in the same cycle as a read address.
REQ-013 SHALL implement FSM IDLE -> COLLECT -> WRITE -> (VERIFY, if enabled) -> COLLECT or DONE -> IDLE.
REQ-014 SHALL, in IDLE, accept start: latch base_addr[31:2]<<2 and byte_count, set busy=1 next cycle; start while busy SHALL be ignored.
REQ-015 SHALL, when byte_count==0, go IDLE -> DONE with no RAM access; done pulses the cycle after start.
REQ-016 SHALL hold in_ready=1 only in COLLECT; in_ready=0 in all other states.
REQ-017 SHALL pack bytes big-endian: 1st byte -> bits [31:24], 4th -> bits [7:0].
REQ-018 SHALL enter WRITE the cycle after the 4th byte of a word or the final byte of the load is accepted.
REQ-019 SHALL, in WRITE, drive chip_enable=1, operation=1 for exactly one cycle with current address and packed word.
REQ-020 SHALL set select = 4'b1111 for full words; final partial word: 1 byte 4'b1000, 2 bytes 4'b1100, 3 bytes 4'b1110; unused data lanes SHALL be zero.
REQ-021 SHALL increment address by 4 after each write, wrapping modulo 2^32.
REQ-022 SHALL, in DONE, pulse done for one cycle, clear busy, return to IDLE.
REQ-023 SHALL drive chip_enable=0, operation=0, addr/select/write_data=0 whenever not accessing RAM.
REQ-024 SHALL sustain 4 bytes per 5 cycles with back-to-back in_valid (verify disabled).

Reset
REQ-025 SHALL, on reset low, immediately force IDLE; in_ready, busy, done, error, chip_enable, operation, addr, select, write_data = 0.
REQ-026 SHALL discard any partially packed word on reset mid-load; no RAM write follows reset release.

Configuration
REQ-027 SHALL, with RAM_LOADER_VERIFY_EN defined, add a VERIFY state after each WRITE: one cycle chip_enable=1, operation=0, same address; compare selected bytes of ram_read_data with written word; mismatch sets error until next accepted start.
REQ-028 SHALL, without RAM_LOADER_VERIFY_EN, omit VERIFY; error tied to 0.

Structure
REQ-029 SHALL place state encodings, RAM operation codes (write/read) and select masks in the shared macro header.
REQ-030 SHALL use one sub-module ram_loader_packer (byte shift-in, lane count, select mask generation).

Verification
REQ-031 base 0x100, count 8, bytes 0x11..0x88 -> writes 0x11223344 @0x100, 0x55667788 @0x104, select 4'b1111, done once.
REQ-032 base 0x200, count 6 -> second write @0x204, data 0xEEFF0000, select 4'b1100.
REQ-033 count 0 -> done one cycle after start, chip_enable never 1.
REQ-034 reset low after 2 bytes of first word -> no RAM write; outputs 0; new start with count 4 loads correctly.
REQ-035 VERIFY_EN, RAM model corrupts byte 0 at 0x104 -> error=1 after that verify, persists past done, clears on next start.
